// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: times each bit by oversampled edge count and sequences checker strobes.
// Parity phase is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_fsm #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [5:0] prescale,
    input  logic       par_en,
    input  logic       start_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [5:0] edge_cnt,
    output logic       dat_samp_en,
    output logic       start_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       deser_en,
    output logic       data_valid,
    output logic       frm_err
);

    localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] StParity = 3'd3;
`endif
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [5:0]      edge_q, edge_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [5:0]      pre_q, pre_d;
    logic            bit_end;
    logic            frame_bad;

    logic            samp_q, samp_d;
    logic            start_chk_q, start_chk_d;
    logic            deser_q, deser_d;
    logic            stp_chk_q, stp_chk_d;
    logic            valid_q, valid_d;
    logic            frm_err_q, frm_err_d;
    logic [5:0]      half_d;
    logic            strobe_d;

`ifdef UART_RX_PARITY_EN
    logic            par_en_q, par_en_d;
    logic            par_bad_q, par_bad_d;
    logic            par_chk_q, par_chk_d;

    assign frame_bad = stp_err | par_bad_q;
`else
    logic            unused_par;

    assign unused_par = par_en ^ par_err;
    assign frame_bad  = stp_err;
`endif

    assign bit_end = (edge_q == pre_q - 6'd1);

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        idx_d     = idx_q;
        pre_d     = pre_q;
        valid_d   = 1'b0;
        frm_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_d  = par_en_q;
        par_bad_d = par_bad_q;
`endif
        if (state_q != StIdle) begin
            edge_d = bit_end ? 6'd0 : edge_q + 6'd1;
        end

        case (state_q)
            StIdle: begin
                edge_d = 6'd0;
                idx_d  = '0;
                if (!rx_in) begin
                    state_d = StStart;
                    pre_d   = prescale;
`ifdef UART_RX_PARITY_EN
                    par_en_d  = par_en;
                    par_bad_d = 1'b0;
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = start_glitch ? StIdle : StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (idx_q == IdxLast) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = par_en_q ? StParity : StStop;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    par_bad_d = par_err;
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    if (frame_bad) begin
                        frm_err_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                    end
                    // A start bit already on the line goes straight to START so no cycle is lost.
                    if (!rx_in) begin
                        state_d = StStart;
                        pre_d   = prescale;
`ifdef UART_RX_PARITY_EN
                        par_en_d  = par_en;
                        par_bad_d = 1'b0;
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                edge_d  = 6'd0;
                idx_d   = '0;
            end
        endcase
    end

    // Strobes are decoded from next-state values so the registered outputs line up with edge_cnt.
    always_comb begin
        half_d      = pre_d >> 1;
        strobe_d    = (state_d != StIdle) && (edge_d == half_d + 6'd2);
        samp_d      = (state_d != StIdle);
        start_chk_d = strobe_d && (state_d == StStart);
        deser_d     = strobe_d && (state_d == StData);
        stp_chk_d   = strobe_d && (state_d == StStop);
`ifdef UART_RX_PARITY_EN
        par_chk_d   = strobe_d && (state_d == StParity);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            edge_q      <= 6'd0;
            idx_q       <= '0;
            pre_q       <= 6'd0;
            samp_q      <= 1'b0;
            start_chk_q <= 1'b0;
            deser_q     <= 1'b0;
            stp_chk_q   <= 1'b0;
            valid_q     <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_q      <= edge_d;
            idx_q       <= idx_d;
            pre_q       <= pre_d;
            samp_q      <= samp_d;
            start_chk_q <= start_chk_d;
            deser_q     <= deser_d;
            stp_chk_q   <= stp_chk_d;
            valid_q     <= valid_d;
            frm_err_q   <= frm_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_en_q  <= 1'b0;
            par_bad_q <= 1'b0;
            par_chk_q <= 1'b0;
        end else begin
            par_en_q  <= par_en_d;
            par_bad_q <= par_bad_d;
            par_chk_q <= par_chk_d;
        end
    end

    assign par_chk_en = par_chk_q;
`else
    assign par_chk_en = 1'b0;
`endif

    assign edge_cnt     = edge_q;
    assign dat_samp_en  = samp_q;
    assign start_chk_en = start_chk_q;
    assign deser_en     = deser_q;
    assign stp_chk_en   = stp_chk_q;
    assign data_valid   = valid_q;
    assign frm_err      = frm_err_q;

endmodule
